// File: rtl/clk_monitor.sv
// clk_monitor: measures period, high time and low time of an asynchronous
// clock-like input in system clock cycles, with a sticky stuck detector.
module clk_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             meas_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise_s;
  logic                   fall_s;
  logic                   sync_last_s;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] low_time_q, low_time_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  logic active_s;
  logic measuring_s;
  logic cnt_sat_s;
  logic update_s;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last_s = sync_q[SYNC_STAGES-1];
  assign rise_s      = sync_last_s & ~edge_q;
  assign fall_s      = ~sync_last_s & edge_q;

  // The counter is about to reach its ceiling without a fresh rising edge.
  assign cnt_sat_s = ~rise_s & (cnt_q >= (CNT_MAX - CNT_ONE));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a low enable overrides every transition.
  always_comb begin
    state_d = state_q;
    if (!meas_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (rise_s) begin
            state_d = MEASURE;
          end else begin
            state_d = ARM;
          end
        end
        MEASURE: begin
          if (cnt_sat_s) begin
            state_d = ARM;
          end else begin
            state_d = MEASURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    active_s    = 1'b0;
    measuring_s = 1'b0;
    case (state_q)
      IDLE: begin
        active_s    = 1'b0;
        measuring_s = 1'b0;
      end
      ARM: begin
        active_s    = 1'b1;
        measuring_s = 1'b0;
      end
      MEASURE: begin
        active_s    = 1'b1;
        measuring_s = 1'b1;
      end
      default: begin
        active_s    = 1'b0;
        measuring_s = 1'b0;
      end
    endcase
  end

  // A measurement completes only on a rise that closes a full high+low cycle.
  assign update_s = meas_en & measuring_s & rise_s & fall_seen_q;

  // Datapath next-state: cycle counter, high capture, results and flags.
  always_comb begin
    cnt_d       = cnt_q;
    high_d      = high_q;
    fall_seen_d = fall_seen_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    low_time_d  = low_time_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;

    if (!meas_en || !active_s) begin
      cnt_d = CNT_ZERO;
    end else if (rise_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (!meas_en || rise_s) begin
      fall_seen_d = 1'b0;
    end else if (measuring_s && fall_s) begin
      fall_seen_d = 1'b1;
    end else begin
      fall_seen_d = fall_seen_q;
    end

    if (meas_en && measuring_s && fall_s) begin
      high_d = cnt_q;
    end else begin
      high_d = high_q;
    end

    // high_q is always below cnt_q here, so the subtraction cannot wrap.
    if (update_s) begin
      period_d    = cnt_q;
      high_time_d = high_q;
      low_time_d  = cnt_q - high_q;
      valid_d     = 1'b1;
    end else begin
      valid_d     = 1'b0;
    end

    if (!meas_en || update_s) begin
      stuck_d = 1'b0;
    end else if (active_s && cnt_sat_s) begin
      stuck_d = 1'b1;
    end else begin
      stuck_d = stuck_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_ZERO;
      high_q      <= CNT_ZERO;
      fall_seen_q <= 1'b0;
      period_q    <= CNT_ZERO;
      high_time_q <= CNT_ZERO;
      low_time_q  <= CNT_ZERO;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      fall_seen_q <= fall_seen_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      low_time_q  <= low_time_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign low_time   = low_time_q;
  assign meas_valid = valid_q;
  assign stuck      = stuck_q;

endmodule
